// File: rtl/syrup_mem_pkg.sv
// Shared definitions for the abstract-memory domain controller:
// per-interface FSM encoding and packed-bus slice helper.
package syrup_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } if_state_t;

    // Low bit index of slice idx in a packed bus of width-wide fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/syrup_if_tracker.sv
// One memory interface of a domain: request latch, replay muxing while the
// domain is stalled, read-data hold and access timeout.
module syrup_if_tracker
    import syrup_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter bit RD_OK   = 1'b1,
    parameter bit WR_OK   = 1'b1,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              drive,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    input  logic [MASK_W-1:0] mask,
    input  logic [DATA_W-1:0] lq,
    input  logic              lrdy,
    input  logic              linit_done,
    input  logic              err_clr,
    output logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] laddr,
    output logic              lre,
    output logic              lwe,
    output logic [DATA_W-1:0] ld,
    output logic [MASK_W-1:0] lmask,
    output logic              ready,
    output logic              timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    if_state_t         state, state_nxt;
    logic              rd_req, wr_req, req;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] d_q, q_q;
    logic [MASK_W-1:0] mask_q;
    logic [TW-1:0]     wait_cnt;
    logic              to_hit;

    assign rd_req = re && RD_OK;
    assign wr_req = we && WR_OK;
    assign req    = rd_req || wr_req;

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A fresh request on a drive cycle overrides a coincident completion.
    always_comb begin
        state_nxt = state;
        if (drive)
            state_nxt = req ? ST_WAIT : ST_IDLE;
        else if (state == ST_WAIT && lrdy)
            state_nxt = ST_DONE;
    end

    always_comb begin
        ready = linit_done && (state != ST_WAIT || lrdy);
        laddr = drive ? addr : addr_q;
        ld    = drive ? d    : d_q;
        lmask = drive ? mask : mask_q;
        lre   = RD_OK && (drive ? re : (rd_q && state == ST_WAIT && !lrdy));
        lwe   = WR_OK && (drive ? we : (wr_q && state == ST_WAIT && !lrdy));
        q     = RD_OK ? ((state == ST_DONE) ? q_q : lq) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= '0;
            d_q    <= '0;
            mask_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            q_q    <= '0;
        end else begin
            if (drive && req) begin
                addr_q <= addr;
                d_q    <= d;
                mask_q <= mask;
                rd_q   <= rd_req;
                wr_q   <= wr_req;
            end
            if (RD_OK && !drive && state == ST_WAIT && lrdy)
                q_q <= lq;
        end
    end

    // Counter saturates at TIMEOUT, so the error set fires exactly once per access
    // and a later err_clr is able to clear the flag.
    assign to_hit = (TIMEOUT != 0) && state == ST_WAIT && !lrdy && wait_cnt == TO_LAST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (drive && req)
                wait_cnt <= '0;
            else if (state == ST_WAIT && wait_cnt != TO_MAX)
                wait_cnt <= wait_cnt + TW'(1);
            if (to_hit)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: rtl/syrup_domain_ctrl_n.sv
// Per-domain controller: holds DRIVE low until every lower-memory access of
// the domain has completed, with optional channel handshake and profiling.
module syrup_domain_ctrl_n
    import syrup_mem_pkg::*;
#(
    parameter int                NUM_IF       = 2,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                MASK_W       = 4,
    parameter logic [NUM_IF-1:0] RD_EN        = '1,
    parameter logic [NUM_IF-1:0] WR_EN        = '1,
    parameter bit                WITH_CHANNEL = 1'b0,
    parameter int                TIMEOUT      = 1024,
    parameter int                CNT_W        = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_IF*ADDR_W-1:0] ADDR,
    input  logic [NUM_IF-1:0]        RE,
    input  logic [NUM_IF-1:0]        WE,
    input  logic [NUM_IF*DATA_W-1:0] D,
    input  logic [NUM_IF*MASK_W-1:0] MASK,
    output logic [NUM_IF*DATA_W-1:0] Q,
    output logic [NUM_IF*ADDR_W-1:0] LADDR,
    output logic [NUM_IF-1:0]        LRE,
    output logic [NUM_IF-1:0]        LWE,
    output logic [NUM_IF*DATA_W-1:0] LD,
    output logic [NUM_IF*MASK_W-1:0] LMASK,
    input  logic [NUM_IF*DATA_W-1:0] LQ,
    input  logic [NUM_IF-1:0]        LRDY,
    input  logic [NUM_IF-1:0]        LINIT_DONE,
    input  logic                     HALT,
    input  logic                     slave_drive_in,
    output logic                     slave_drive_out,
    input  logic                     master_drive_in,
    output logic                     master_drive_out,
    output logic                     DRIVE,
    output logic [NUM_IF-1:0]        TIMEOUT_ERR,
    input  logic                     ERR_CLR,
    input  logic                     CNT_CLR,
    output logic [CNT_W-1:0]         DRIVE_CNT,
    output logic [CNT_W-1:0]         STALL_CNT
);

    logic [NUM_IF-1:0] ready;
    logic              next_ready;
    logic              drive_raw;

    for (genvar i = 0; i < NUM_IF; i++) begin : g_if
        syrup_if_tracker #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .MASK_W  (MASK_W),
            .RD_OK   (RD_EN[i]),
            .WR_OK   (WR_EN[i]),
            .TIMEOUT (TIMEOUT)
        ) u_trk (
            .CLK         (CLK),
            .RST         (RST),
            .drive       (DRIVE),
            .re          (RE[i]),
            .we          (WE[i]),
            .addr        (ADDR[slice_lo(i, ADDR_W) +: ADDR_W]),
            .d           (D[slice_lo(i, DATA_W) +: DATA_W]),
            .mask        (MASK[slice_lo(i, MASK_W) +: MASK_W]),
            .lq          (LQ[slice_lo(i, DATA_W) +: DATA_W]),
            .lrdy        (LRDY[i]),
            .linit_done  (LINIT_DONE[i]),
            .err_clr     (ERR_CLR),
            .q           (Q[slice_lo(i, DATA_W) +: DATA_W]),
            .laddr       (LADDR[slice_lo(i, ADDR_W) +: ADDR_W]),
            .lre         (LRE[i]),
            .lwe         (LWE[i]),
            .ld          (LD[slice_lo(i, DATA_W) +: DATA_W]),
            .lmask       (LMASK[slice_lo(i, MASK_W) +: MASK_W]),
            .ready       (ready[i]),
            .timeout_err (TIMEOUT_ERR[i])
        );
    end

    assign next_ready = (&ready) && !HALT;

    if (WITH_CHANNEL) begin : g_ch
        assign slave_drive_out  = next_ready && master_drive_in;
        assign master_drive_out = next_ready && slave_drive_in;
        assign drive_raw        = next_ready && slave_drive_in && master_drive_in;
    end else begin : g_noch
        logic unused_ch;
        assign unused_ch        = slave_drive_in ^ master_drive_in;
        assign slave_drive_out  = next_ready;
        assign master_drive_out = next_ready;
        assign drive_raw        = next_ready;
    end

    assign DRIVE = drive_raw && !RST;

    always_ff @(posedge CLK) begin
        if (RST || CNT_CLR) begin
            DRIVE_CNT <= '0;
            STALL_CNT <= '0;
        end else if (DRIVE) begin
            if (~&DRIVE_CNT) DRIVE_CNT <= DRIVE_CNT + CNT_W'(1);
        end else begin
            if (~&STALL_CNT) STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_syrup_domain_ctrl_n.sv
// Directed bench for the domain controller: an access-level reference model
// checked every cycle, plus hand-computed checkpoints along the scenario.
module tb_syrup_domain_ctrl_n;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N*AW-1:0] ADDR, LADDR;
    logic [N-1:0]    RE, WE, LRE, LWE, LRDY, LINIT_DONE, TIMEOUT_ERR;
    logic [N*DW-1:0] D, Q, LD, LQ;
    logic [N*MW-1:0] MASK, LMASK;
    logic            HALT, slave_drive_in, master_drive_in, ERR_CLR, CNT_CLR;
    logic            slave_drive_out, master_drive_out, DRIVE;
    logic [CW-1:0]   DRIVE_CNT, STALL_CNT;

    always #5 CLK = ~CLK;

    syrup_domain_ctrl_n #(
        .NUM_IF(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
        .RD_EN('1), .WR_EN('1), .WITH_CHANNEL(1'b1), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .RE(RE), .WE(WE), .D(D), .MASK(MASK),
        .Q(Q), .LADDR(LADDR), .LRE(LRE), .LWE(LWE), .LD(LD), .LMASK(LMASK),
        .LQ(LQ), .LRDY(LRDY), .LINIT_DONE(LINIT_DONE), .HALT(HALT),
        .slave_drive_in(slave_drive_in), .slave_drive_out(slave_drive_out),
        .master_drive_in(master_drive_in), .master_drive_out(master_drive_out),
        .DRIVE(DRIVE), .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR),
        .CNT_CLR(CNT_CLR), .DRIVE_CNT(DRIVE_CNT), .STALL_CNT(STALL_CNT)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding access per interface, its latched
    // request, whether read data is being held, and completed wait cycles.
    logic [N-1:0]  m_pend, m_rd, m_wr, m_cap, m_err;
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_d    [N];
    logic [MW-1:0] m_mask [N];
    logic [DW-1:0] m_q    [N];
    int            m_wait [N];
    int            m_dcnt, m_scnt;

    function automatic logic m_nr();
        logic all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < N; i++)
            if (!LINIT_DONE[i] || (m_pend[i] && !LRDY[i])) all_ok = 1'b0;
        return all_ok && !HALT;
    endfunction

    function automatic logic m_drive();
        return !RST && m_nr() && slave_drive_in && master_drive_in;
    endfunction

    always @(posedge CLK) begin
        logic drv;
        drv = m_drive();
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] <= 1'b0; m_rd[i] <= 1'b0; m_wr[i] <= 1'b0;
                m_cap[i]  <= 1'b0; m_err[i] <= 1'b0;
                m_addr[i] <= '0; m_d[i] <= '0; m_mask[i] <= '0; m_q[i] <= '0;
                m_wait[i] <= 0;
            end
            m_dcnt <= 0;
            m_scnt <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (drv) begin
                    if (RE[i] || WE[i]) begin
                        m_pend[i] <= 1'b1;
                        m_rd[i]   <= RE[i];
                        m_wr[i]   <= WE[i];
                        m_addr[i] <= ADDR[i*AW +: AW];
                        m_d[i]    <= D[i*DW +: DW];
                        m_mask[i] <= MASK[i*MW +: MW];
                        m_wait[i] <= 0;
                    end else begin
                        m_pend[i] <= 1'b0;
                    end
                    m_cap[i] <= 1'b0;
                end else if (m_pend[i] && LRDY[i]) begin
                    m_pend[i] <= 1'b0;
                    m_cap[i]  <= 1'b1;
                    m_q[i]    <= LQ[i*DW +: DW];
                end else if (m_pend[i] && m_wait[i] < TO) begin
                    m_wait[i] <= m_wait[i] + 1;
                end
                if (m_pend[i] && !LRDY[i] && m_wait[i] == TO - 1) m_err[i] <= 1'b1;
                else if (ERR_CLR)                                   m_err[i] <= 1'b0;
            end
            if (CNT_CLR) begin
                m_dcnt <= 0;
                m_scnt <= 0;
            end else if (drv) begin
                if (m_dcnt < CMAX) m_dcnt <= m_dcnt + 1;
            end else begin
                if (m_scnt < CMAX) m_scnt <= m_scnt + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            logic            drv, nr;
            logic [N*AW-1:0] e_addr;
            logic [N*DW-1:0] e_d, e_q;
            logic [N*MW-1:0] e_mask;
            logic [N-1:0]    e_lre, e_lwe;
            nr  = m_nr();
            drv = m_drive();
            for (int i = 0; i < N; i++) begin
                e_addr[i*AW +: AW] = drv ? ADDR[i*AW +: AW] : m_addr[i];
                e_d[i*DW +: DW]    = drv ? D[i*DW +: DW]    : m_d[i];
                e_mask[i*MW +: MW] = drv ? MASK[i*MW +: MW] : m_mask[i];
                e_lre[i] = drv ? RE[i] : (m_pend[i] && m_rd[i] && !LRDY[i]);
                e_lwe[i] = drv ? WE[i] : (m_pend[i] && m_wr[i] && !LRDY[i]);
                e_q[i*DW +: DW]    = m_cap[i] ? m_q[i] : LQ[i*DW +: DW];
            end
            check("DRIVE", DRIVE, drv);
            check("slave_drive_out", slave_drive_out, nr && master_drive_in);
            check("master_drive_out", master_drive_out, nr && slave_drive_in);
            check("LADDR", LADDR, e_addr);
            check("LD", LD, e_d);
            check("LMASK", LMASK, e_mask);
            check("LRE", LRE, e_lre);
            check("LWE", LWE, e_lwe);
            check("Q", Q, e_q);
            check("TIMEOUT_ERR", TIMEOUT_ERR, m_err);
            check("DRIVE_CNT", DRIVE_CNT, m_dcnt);
            check("STALL_CNT", STALL_CNT, m_scnt);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; ADDR = '0; RE = '0; WE = '0; D = '0; MASK = '0; LQ = '0;
        LRDY = '0; LINIT_DONE = 2'b11; HALT = 1'b0; slave_drive_in = 1'b1;
        master_drive_in = 1'b1; ERR_CLR = 1'b0; CNT_CLR = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        #1;
        check("rst drive", DRIVE, 1'b0);
        check("rst dcnt", DRIVE_CNT, 4'd0);
        check("rst scnt", STALL_CNT, 4'd0);
        check("rst lre", LRE, 2'b00);

        // init gating
        RST = 1'b0; LINIT_DONE = 2'b01;
        repeat (3) tick();
        #1;
        check("init drive", DRIVE, 1'b0);
        check("init scnt", STALL_CNT, 4'd3);
        LINIT_DONE = 2'b11;
        #1;
        check("init done drive", DRIVE, 1'b1);

        // single read on interface 0
        RE = 2'b01; ADDR[15:0] = 16'h0040;
        #1;
        check("rd laddr pass", LADDR[15:0], 16'h0040);
        check("rd lre pass", LRE[0], 1'b1);
        tick();
        RE = 2'b00; ADDR[15:0] = 16'h0099;
        #1;
        check("rd stall", DRIVE, 1'b0);
        check("rd lre replay", LRE[0], 1'b1);
        check("rd laddr replay", LADDR[15:0], 16'h0040);
        repeat (2) tick();
        LRDY = 2'b01; LQ[15:0] = 16'hDEAD;
        #1;
        check("rd done drive", DRIVE, 1'b1);
        check("rd q", Q[15:0], 16'hDEAD);
        tick();
        LRDY = 2'b00; LQ = '0;

        // read on 0, write on 1; interface 1 finishes three cycles early
        RE = 2'b01; WE = 2'b10; ADDR = {16'h0200, 16'h0100};
        D = {16'h1234, 16'h0000}; MASK = {4'h3, 4'h0};
        tick();
        RE = 2'b00; WE = 2'b00; D = '0; MASK = '0;
        #1;
        check("dual stall", DRIVE, 1'b0);
        check("dual lwe1", LWE, 2'b10);
        check("dual lre0", LRE, 2'b01);
        check("dual ld1", LD[31:16], 16'h1234);
        check("dual lmask1", LMASK[7:4], 4'h3);
        tick();
        LRDY = 2'b10; LQ[31:16] = 16'h5555;
        #1;
        check("dual lwe1 drop", LWE[1], 1'b0);
        check("dual still stall", DRIVE, 1'b0);
        tick();
        LRDY = 2'b00; LQ[31:16] = 16'h7777;
        #1;
        check("dual q1 hold", Q[31:16], 16'h5555);
        check("dual lwe1 idle", LWE[1], 1'b0);
        repeat (2) tick();
        LRDY = 2'b01; LQ[15:0] = 16'hBEEF;
        #1;
        check("dual release", DRIVE, 1'b1);
        check("dual q1 final", Q[31:16], 16'h5555);
        check("dual q0 final", Q[15:0], 16'hBEEF);
        tick();
        LRDY = 2'b00; LQ = '0;

        // timeout after 8 wait cycles; a same-cycle clear loses to the set
        RE = 2'b01; ADDR[15:0] = 16'h0300;
        tick();
        RE = 2'b00;
        repeat (7) tick();
        #1;
        check("to before", TIMEOUT_ERR, 2'b00);
        ERR_CLR = 1'b1;
        tick();
        #1;
        check("to set", TIMEOUT_ERR, 2'b01);
        check("to stall", DRIVE, 1'b0);
        tick();
        #1;
        check("to clr", TIMEOUT_ERR, 2'b00);
        ERR_CLR = 1'b0;
        tick();
        #1;
        check("to still stall", DRIVE, 1'b0);
        check("to lre replay", LRE[0], 1'b1);
        LRDY = 2'b01;
        #1;
        check("to release", DRIVE, 1'b1);
        tick();
        LRDY = 2'b00;

        // channel handshake and halt
        master_drive_in = 1'b0;
        #1;
        check("ch drive", DRIVE, 1'b0);
        check("ch master_out", master_drive_out, 1'b1);
        check("ch slave_out", slave_drive_out, 1'b0);
        master_drive_in = 1'b1; HALT = 1'b1;
        #1;
        check("halt drive", DRIVE, 1'b0);
        check("halt slave_out", slave_drive_out, 1'b0);
        check("halt master_out", master_drive_out, 1'b0);
        tick();
        HALT = 1'b0;

        // counter saturation and clear
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        #1;
        check("cnt clr d", DRIVE_CNT, 4'd0);
        check("cnt clr s", STALL_CNT, 4'd0);
        repeat (20) tick();
        #1;
        check("cnt sat", DRIVE_CNT, 4'd15);
        check("cnt no stall", STALL_CNT, 4'd0);
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        #1;
        check("cnt clr wins", DRIVE_CNT, 4'd0);

        // reset while an access is outstanding
        RE = 2'b01; ADDR[15:0] = 16'h0500;
        tick();
        RE = 2'b00;
        #1;
        check("rstw lre", LRE[0], 1'b1);
        RST = 1'b1;
        #1;
        check("rstw drive", DRIVE, 1'b0);
        check("rstw lre hold", LRE[0], 1'b1);
        tick();
        #1;
        check("rstw lre drop", LRE[0], 1'b0);
        RST = 1'b0;
        tick();
        #1;
        check("rstw drive back", DRIVE, 1'b1);
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
